// File: rtl/pace_pkg.sv
// Shared types and helpers for the pace ticker: counter sizing and the
// zone/speed-level to tick-period mapping.
package pace_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pace_state_e;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width needed to hold the slowest period the zone count can produce.
    function automatic int unsigned cnt_w_of(input int unsigned zones,
                                             input int unsigned min_period,
                                             input int unsigned step);
        return clog2(min_period + step * (zones + 32'd1) + 32'd1);
    endfunction

    // Farther zones add slowdown steps, higher speed levels remove them; never below zero.
    function automatic int unsigned period_of(input int unsigned z,
                                              input int unsigned l,
                                              input int unsigned min_period,
                                              input int unsigned step);
        int unsigned d;
        d = ((z + 32'd2) > l) ? (z + 32'd2 - l) : 32'd0;
        return min_period + step * d;
    endfunction

endpackage

// File: rtl/pace_period_calc.sv
// Combinational period lookup: zone priority encode, speed MSB encode,
// clipped step count and multiply-add, plus the run qualifier.
module pace_period_calc
    import pace_pkg::*;
#(
    parameter int unsigned ZONES      = 3,
    parameter int unsigned SPEED_W    = 4,
    parameter int unsigned MIN_PERIOD = 10,
    parameter int unsigned STEP       = 5,
    parameter int unsigned CNT_W      = cnt_w_of(ZONES, MIN_PERIOD, STEP)
) (
    input  logic               en,
    input  logic [SPEED_W-1:0] speed,
    input  logic [ZONES-1:0]   zone,
    output logic [CNT_W-1:0]   period_c,
    output logic               valid_c
);

    int unsigned zone_idx;
    int unsigned level;

    // Lowest set zone bit wins when several are set.
    always_comb begin
        zone_idx = 32'd0;
        for (int i = int'(ZONES) - 1; i >= 0; i--) begin
            if (zone[i]) begin
                zone_idx = unsigned'(i);
            end
        end
    end

    // Speed level is the position of the most significant set bit.
    always_comb begin
        level = 32'd0;
        for (int i = 0; i < int'(SPEED_W); i++) begin
            if (speed[i]) begin
                level = unsigned'(i);
            end
        end
    end

    assign valid_c  = en && (speed != '0) && (zone != '0);
    assign period_c = CNT_W'(period_of(zone_idx, level, MIN_PERIOD, STEP));

endmodule

// File: rtl/pace_ticker.sv
// Tick generator: one-cycle pulse every cur_period cycles while running,
// with period changes applied only on tick edges and a wrapping tick total.
module pace_ticker
    import pace_pkg::*;
#(
    parameter int unsigned ZONES      = 3,
    parameter int unsigned SPEED_W    = 4,
    parameter int unsigned MIN_PERIOD = 10,
    parameter int unsigned STEP       = 5,
    parameter int unsigned TOTAL_W    = 16,
    localparam int unsigned CNT_W     = cnt_w_of(ZONES, MIN_PERIOD, STEP)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [SPEED_W-1:0] speed,
    input  logic [ZONES-1:0]   zone,
    input  logic               clr,
    output logic               tick,
    output logic               active,
    output logic [CNT_W-1:0]   cur_period,
    output logic [TOTAL_W-1:0] tick_total
);

    pace_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               tick_q, tick_d;
    logic               active_q, active_d;
    logic [TOTAL_W-1:0] total_q, total_d;

    logic [CNT_W-1:0]   new_period_c;
    logic               go_c;

    pace_period_calc #(
        .ZONES      (ZONES),
        .SPEED_W    (SPEED_W),
        .MIN_PERIOD (MIN_PERIOD),
        .STEP       (STEP),
        .CNT_W      (CNT_W)
    ) u_calc (
        .en       (en),
        .speed    (speed),
        .zone     (zone),
        .period_c (new_period_c),
        .valid_c  (go_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            active_q <= active_d;
            total_q  <= total_d;
        end
    end

    // Losing go always wins over a coincident terminal count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        tick_d   = 1'b0;
        active_d = active_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d    = '0;
                period_d = '0;
                active_d = 1'b0;
                if (go_c) begin
                    state_d  = ST_RUN;
                    period_d = new_period_c;
                    active_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!go_c) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    period_d = '0;
                    active_d = 1'b0;
                end else if (cnt_q == (period_q - CNT_W'(1))) begin
                    tick_d   = 1'b1;
                    cnt_d    = '0;
                    period_d = new_period_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                period_d = '0;
                active_d = 1'b0;
            end
        endcase
    end

    // A clear that lands on a tick edge still counts that tick.
    always_comb begin
        total_d = total_q;
        if (clr) begin
            total_d = tick_d ? TOTAL_W'(1) : '0;
        end else if (tick_d) begin
            total_d = total_q + TOTAL_W'(1);
        end
    end

    assign tick       = tick_q;
    assign active     = active_q;
    assign cur_period = period_q;
    assign tick_total = total_q;

endmodule

// File: tb/tb_pace_ticker.sv
// Scoreboard bench for pace_ticker: expected tick cycles, periods and totals
// are queued when stimulus is applied and popped as ticks appear.
module tb_pace_ticker;

    localparam int unsigned CNT_W = pace_pkg::cnt_w_of(3, 10, 5);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             en    = 1'b0;
    logic             clr   = 1'b0;
    logic [3:0]       speed = 4'd0;
    logic [2:0]       zone  = 3'd0;

    logic             tick, active;
    logic [CNT_W-1:0] cur_period;
    logic [15:0]      tick_total;
    logic             tick4, active4;
    logic [CNT_W-1:0] cur_period4;
    logic [3:0]       tick_total4;

    pace_ticker u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .speed      (speed),
        .zone       (zone),
        .clr        (clr),
        .tick       (tick),
        .active     (active),
        .cur_period (cur_period),
        .tick_total (tick_total)
    );

    pace_ticker #(.TOTAL_W(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .speed      (speed),
        .zone       (zone),
        .clr        (clr),
        .tick       (tick4),
        .active     (active4),
        .cur_period (cur_period4),
        .tick_total (tick_total4)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        int unsigned per;
        int unsigned tot;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned model_tot = 0;
    int unsigned n_chk     = 0;
    int unsigned n_pass    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: every observed tick must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && tick) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick_cycle", cyc, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tick_cycle", cyc, mon_e.cyc);
                chk("tick_period", 32'(cur_period), mon_e.per);
                chk("tick_total", 32'(tick_total), mon_e.tot);
                chk("tick_total_w4", 32'(tick_total4), mon_e.tot % 16);
                chk("tick_w4_aligned", 32'(tick4), 1);
            end
        end
    end

    task automatic drive(input logic e, input logic [3:0] s, input logic [2:0] z);
        @(posedge clk);
        #1;
        en    = e;
        speed = s;
        zone  = z;
    endtask

    task automatic push_one(input int unsigned c, input int unsigned p, input int unsigned t);
        exp_t e;
        e.cyc = c;
        e.per = p;
        e.tot = t;
        exp_q.push_back(e);
    endtask

    task automatic push_ticks(input int unsigned e0, input int unsigned per, input int unsigned count);
        for (int unsigned k = 1; k <= count; k++) begin
            model_tot = (model_tot + 1) % 65536;
            push_one(e0 + k * per, per, model_tot);
        end
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int unsigned bound);
        int unsigned i;
        i = 0;
        while (exp_q.size() != 0 && i < bound) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic stop_check(input string tag);
        drive(1'b0, speed, zone);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_active"}, 32'(active), 0);
        chk({tag, "_idle_period"}, 32'(cur_period), 0);
    endtask

    task automatic run_basic(input logic [3:0] s, input logic [2:0] z,
                             input int unsigned per, input int unsigned count, input string tag);
        int unsigned n;
        drive(1'b1, s, z);
        n = cyc;
        push_ticks(n + 1, per, count);
        wait_cyc(n + 1);
        @(negedge clk);
        chk({tag, "_active"}, 32'(active), 1);
        chk({tag, "_period"}, 32'(cur_period), per);
        wait_drain(per * (count + 2));
        stop_check(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_period", 32'(cur_period), 0);
        chk("rst_total", 32'(tick_total), 0);
        rst_n = 1'b1;

        run_basic(4'd4, 3'b001, 10, 3, "base");
        run_basic(4'd1, 3'b100, 30, 2, "slow");
        run_basic(4'd15, 3'b100, 15, 2, "fast");

        // Period change mid-count only applies after the next tick.
        drive(1'b1, 4'd1, 3'b001);
        n = cyc;
        model_tot++;
        push_one(n + 21, 10, model_tot);
        model_tot++;
        push_one(n + 31, 10, model_tot);
        wait_cyc(n + 6);
        speed = 4'd4;
        wait_cyc(n + 10);
        chk("chg_period_held", 32'(cur_period), 20);
        wait_drain(60);
        stop_check("chg");

        // Abort at terminal count, with multi-hot zone using lowest index.
        drive(1'b1, 4'd4, 3'b011);
        n = cyc;
        wait_cyc(n + 1);
        chk("multi_zone_period", 32'(cur_period), 10);
        wait_cyc(n + 10);
        speed = 4'd0;
        wait_cyc(n + 11);
        chk("abort_tick", 32'(tick), 0);
        chk("abort_active", 32'(active), 0);
        chk("abort_period", 32'(cur_period), 0);
        en    = 1'b0;
        speed = 4'd4;

        // Asynchronous reset mid-count.
        drive(1'b1, 4'd4, 3'b001);
        n = cyc;
        wait_cyc(n + 5);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("async_tick", 32'(tick), 0);
        chk("async_active", 32'(active), 0);
        chk("async_period", 32'(cur_period), 0);
        chk("async_total", 32'(tick_total), 0);
        chk("async_total_w4", 32'(tick_total4), 0);
        model_tot = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Clear coincident with a tick leaves the total at one.
        drive(1'b1, 4'd4, 3'b001);
        n = cyc;
        push_ticks(n + 1, 10, 2);
        wait_cyc(n + 30);
        clr = 1'b1;
        model_tot = 1;
        push_one(n + 31, 10, 1);
        wait_cyc(n + 31);
        clr = 1'b0;
        wait_drain(40);
        stop_check("clr");

        wait_cyc(cyc + 1);
        clr = 1'b1;
        wait_cyc(cyc + 1);
        clr = 1'b0;
        chk("clr_idle_total", 32'(tick_total), 0);
        chk("clr_idle_total_w4", 32'(tick_total4), 0);
        model_tot = 0;

        // Seventeen ticks wrap the 4-bit total back to one.
        drive(1'b1, 4'd4, 3'b001);
        n = cyc;
        push_ticks(n + 1, 10, 17);
        wait_drain(250);
        chk("wrap_total16", 32'(tick_total), 17);
        chk("wrap_total_w4", 32'(tick_total4), 1);
        stop_check("wrap");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
